multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Central control FSM of the multicycle MIPS core. Sequences the shared datapath (instruction/data memory port, decode latch, execute latch, register-file write port, PC) through fetch, decode, execute, memory and write-back steps per instruction. Consumes decode-stage control bits and an execute-stage branch decision; emits one-cycle enables. Also counts retired instructions and watchdogs memory wait states.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive cycles waiting for `mem_ready` before a fault.
- COUNT_W, 32: width of the retired-instruction counter.
- HALT_OPCODE, 6'b111111: opcode that halts the sequencer.
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset.
- run  in  1  level; start/continue execution.
- opcode  in  6  Instruction[31:26] from the instruction register.
- mem_r_en  in  1  decoded load.
- mem_w_en  in  1  decoded store.
- wb_en  in  1  decoded register write-back.
- br_type  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP.
- branch_taken  in  1  execute-stage condition result, valid in EXEC.
- mem_ready  in  1  memory port completes the current request this cycle.
- pc_write  out  1  load PC.
- pc_src_branch  out  1  PC source = branch target (else PC+4).
- ir_write  out  1  load instruction register.
- id_latch  out  1  capture decode outputs.
- exe_latch  out  1  capture ALU result.
- mem_req  out  1  memory request active.
- mem_we  out  1  request is a write.
- reg_write  out  1  register-file write enable.
- busy  out  1  state not IDLE/HALT.
- fault  out  1  sticky memory-timeout flag.
- state  out  3  current state encoding.
- instr_count  out  COUNT_W  retired instructions, saturating.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE: all strobes 0; run=1 -> FETCH.
- FETCH: mem_req=1, mem_we=0; wait while mem_ready=0; on mem_ready: ir_write=1, pc_write=1 (PC+4) same cycle -> DECODE.
- DECODE: id_latch=1. opcode==HALT_OPCODE -> HALT (not counted). opcode==0 (NOP) -> retire. Else -> EXEC.
- EXEC: exe_latch=1. If br_type==11, or br_type in {01,10} with branch_taken=1: pc_write=1, pc_src_branch=1. Next: mem_w_en|mem_r_en -> MEM; else wb_en -> WB; else retire.
- MEM: mem_req=1, mem_we=mem_w_en; wait while mem_ready=0; on mem_ready: mem_r_en&wb_en&!mem_w_en -> WB, else retire. mem_r_en&mem_w_en both 1: treated as store, no WB.
- WB: reg_write=1 -> retire.
- Retire: instr_count+1 (saturates at all-ones); next = FETCH if run=1, else IDLE. run dropping mid-instruction never aborts it.
- Timeout: wait counter clears on entering FETCH/MEM and on mem_ready; increments each cycle mem_req=1 and mem_ready=0; reaching MEM_TIMEOUT -> HALT, fault=1, no strobes that cycle.
- HALT: absorbing; only rst exits. fault sticky until rst.

## Timing
- Reset (rst=0 at edge): state=IDLE, instr_count=0, fault=0, wait counter=0; all strobes 0 since they decode from IDLE.
- Strobes Moore from state, except ir_write/pc_write in FETCH and MEM exit, which are qualified by mem_ready in the same cycle.
- Cycles per instruction with zero wait states: NOP 2, branch/ALU-no-WB 3, ALU 4, store 4, load 5; each wait cycle adds 1.
- IDLE->FETCH: one cycle after run sampled high.
- Reset asserted mid-MEM: request dropped next cycle; no reg_write, count unchanged.

## Structure
- Package mips_seq_pkg: state enum/localparams, br_type encodings (BR_NONE, BR_BEZ, BR_BNE, BR_JMP), default HALT opcode.
- One sub-module: mem_wait_timer (clear, count-enable, MEM_TIMEOUT compare, expired output).
- Top holds next-state logic, strobe decode, retire counter.

## Test plan
- Reset then run=1, mem_ready=1, ALU op (wb_en=1): states 1,2,3,5,1; reg_write pulses once in cycle 4; instr_count=1.
- Load with mem_ready low 3 cycles in MEM: mem_req high 4 cycles, mem_we=0, then WB; total 8 cycles; count=1.
- BNE with branch_taken=1: pc_write & pc_src_branch together in EXEC only; back to FETCH; no mem_req in EXEC.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH: after 4 wait cycles state=6, fault=1, all strobes 0; rst=0 clears to IDLE, fault=0.
- run dropped during store MEM: store completes (mem_we=1 on ready), count increments, state -> IDLE; HALT_OPCODE -> state 6, count unchanged.

Source files
------------

// File: rtl/mips_seq_pkg.sv
// Shared types and constants for the multicycle MIPS control sequencer.
//   state_e   : sequencer state encoding, visible on the state output
//   br_e      : branch-type encoding carried in br_type
//   strobes_t : bundle of one-cycle datapath enables
package mips_seq_pkg;

   localparam int unsigned STATE_W  = 3;
   localparam int unsigned OPCODE_W = 6;
   localparam int unsigned BR_W     = 2;

   localparam int unsigned MEM_TIMEOUT_DEF = 16;
   localparam int unsigned COUNT_W_DEF     = 32;

   localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEF = 6'b111111;
   localparam logic [OPCODE_W-1:0] NOP_OPCODE      = 6'b000000;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_e;

   typedef enum logic [BR_W-1:0] {
      BR_NONE = 2'b00,
      BR_BEZ  = 2'b01,
      BR_BNE  = 2'b10,
      BR_JMP  = 2'b11
   } br_e;

   typedef struct packed {
      logic pc_write;
      logic pc_src_branch;
      logic ir_write;
      logic id_latch;
      logic exe_latch;
      logic mem_req;
      logic mem_we;
      logic reg_write;
   } strobes_t;

   // Jumps always redirect; conditional branches only when the execute stage says so.
   function automatic logic branch_redirect(input logic [BR_W-1:0] br_type,
                                            input logic            taken);
      return (br_type == BR_JMP) ||
             (((br_type == BR_BEZ) || (br_type == BR_BNE)) && taken);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Watchdog for memory wait states.
//   clk        : core clock
//   rst        : synchronous active-low reset
//   i_clear    : restart the count (new request or request completed)
//   i_count_en : a request is outstanding and not ready this cycle
//   o_expired  : this cycle is the MEM_TIMEOUT-th consecutive wait cycle
module mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_count_en,
   output logic o_expired
);

   localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

   logic [CNT_W-1:0] r_count;

   // Expiry is flagged during the final permitted wait so the FSM leaves on that edge.
   assign o_expired = i_count_en && (r_count == LAST_WAIT);

   // Consecutive wait-cycle counter; holds once expired.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_count_en && !o_expired) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Central control FSM of the multicycle MIPS core.
//   clk, rst               : clock, synchronous active-low reset
//   run                    : start / continue execution
//   opcode                 : instruction[31:26]
//   mem_r_en/mem_w_en/wb_en: decoded load / store / register write-back
//   br_type, branch_taken  : branch kind and execute-stage condition
//   mem_ready              : memory completes the current request this cycle
//   pc_write..reg_write    : one-cycle datapath enables
//   busy, fault, state     : status (fault sticky until reset)
//   instr_count            : saturating retired-instruction count
module multicycle_sequencer
   import mips_seq_pkg::*;
#(
   parameter int unsigned          MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int unsigned          COUNT_W     = COUNT_W_DEF,
   parameter logic [OPCODE_W-1:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_r_en,
   input  logic                mem_w_en,
   input  logic                wb_en,
   input  logic [BR_W-1:0]     br_type,
   input  logic                branch_taken,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_src_branch,
   output logic                ir_write,
   output logic                id_latch,
   output logic                exe_latch,
   output logic                mem_req,
   output logic                mem_we,
   output logic                reg_write,
   output logic                busy,
   output logic                fault,
   output logic [STATE_W-1:0]  state,
   output logic [COUNT_W-1:0]  instr_count
);

   state_e             r_state;
   state_e             w_next;
   logic [COUNT_W-1:0] r_count;
   logic               r_fault;
   strobes_t           w_strb;
   logic               w_retire;
   logic               w_waiting;
   logic               w_timer_clear;
   logic               w_expired;

   // A wait cycle is any cycle with a request outstanding and no ready.
   assign w_waiting     = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
   assign w_timer_clear = mem_ready ||
                          (((w_next == S_FETCH) || (w_next == S_MEM)) && (w_next != r_state));

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_timer_clear),
      .i_count_en (w_waiting),
      .o_expired  (w_expired)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and strobe decode.
   always_comb begin
      w_next   = r_state;
      w_strb   = '0;
      w_retire = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (run) w_next = S_FETCH;
         end
         S_FETCH: begin
            w_strb.mem_req = 1'b1;
            if (mem_ready) begin
               w_strb.ir_write = 1'b1;
               w_strb.pc_write = 1'b1;
               w_next          = S_DECODE;
            end
         end
         S_DECODE: begin
            w_strb.id_latch = 1'b1;
            if (opcode == HALT_OPCODE) begin
               w_next = S_HALT;
            end else if (opcode == NOP_OPCODE) begin
               w_retire = 1'b1;
            end else begin
               w_next = S_EXEC;
            end
         end
         S_EXEC: begin
            w_strb.exe_latch = 1'b1;
            if (branch_redirect(br_type, branch_taken)) begin
               w_strb.pc_write      = 1'b1;
               w_strb.pc_src_branch = 1'b1;
            end
            if (mem_r_en || mem_w_en) begin
               w_next = S_MEM;
            end else if (wb_en) begin
               w_next = S_WB;
            end else begin
               w_retire = 1'b1;
            end
         end
         S_MEM: begin
            w_strb.mem_req = 1'b1;
            w_strb.mem_we  = mem_w_en;
            if (mem_ready) begin
               // A combined read+write is a store: no write-back.
               if (mem_r_en && wb_en && !mem_w_en) begin
                  w_next = S_WB;
               end else begin
                  w_retire = 1'b1;
               end
            end
         end
         S_WB: begin
            w_strb.reg_write = 1'b1;
            w_retire         = 1'b1;
         end
         S_HALT: begin
            w_next = S_HALT;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase

      // Instruction boundary: dropping run only takes effect here.
      if (w_retire) begin
         w_next = run ? S_FETCH : S_IDLE;
      end

      // The expiring cycle has no ready, so no ir/pc/reg strobe can fire in it.
      if (w_expired) begin
         w_next   = S_HALT;
         w_retire = 1'b0;
      end
   end

   // Sticky memory-timeout flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fault <= 1'b0;
      end else if (w_expired) begin
         r_fault <= 1'b1;
      end
   end

   // Saturating retired-instruction counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count <= '0;
      end else if (w_retire && (r_count != '1)) begin
         r_count <= r_count + COUNT_W'(1);
      end
   end

   assign pc_write      = w_strb.pc_write;
   assign pc_src_branch = w_strb.pc_src_branch;
   assign ir_write      = w_strb.ir_write;
   assign id_latch      = w_strb.id_latch;
   assign exe_latch     = w_strb.exe_latch;
   assign mem_req       = w_strb.mem_req;
   assign mem_we        = w_strb.mem_we;
   assign reg_write     = w_strb.reg_write;
   assign busy          = (r_state != S_IDLE) && (r_state != S_HALT);
   assign fault         = r_fault;
   assign state         = r_state;
   assign instr_count   = r_count;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer (MEM_TIMEOUT=4, COUNT_W=4).
module tb_multicycle_sequencer;

   localparam int unsigned TO  = 4;
   localparam int unsigned CW  = 4;
   localparam int          SAT = 15;

   logic          clk;
   logic          rst;
   logic          run;
   logic [5:0]    opcode;
   logic          mem_r_en;
   logic          mem_w_en;
   logic          wb_en;
   logic [1:0]    br_type;
   logic          branch_taken;
   logic          mem_ready;
   logic          pc_write;
   logic          pc_src_branch;
   logic          ir_write;
   logic          id_latch;
   logic          exe_latch;
   logic          mem_req;
   logic          mem_we;
   logic          reg_write;
   logic          busy;
   logic          fault;
   logic [2:0]    state;
   logic [CW-1:0] instr_count;

   multicycle_sequencer #(
      .MEM_TIMEOUT (TO),
      .COUNT_W     (CW),
      .HALT_OPCODE (6'b111111)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .run           (run),
      .opcode        (opcode),
      .mem_r_en      (mem_r_en),
      .mem_w_en      (mem_w_en),
      .wb_en         (wb_en),
      .br_type       (br_type),
      .branch_taken  (branch_taken),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_src_branch (pc_src_branch),
      .ir_write      (ir_write),
      .id_latch      (id_latch),
      .exe_latch     (exe_latch),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .reg_write     (reg_write),
      .busy          (busy),
      .fault         (fault),
      .state         (state),
      .instr_count   (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] op;
      logic       r, w, wb;
      logic [1:0] br;
      logic       tk;
      int         fw;
      int         mw;
      logic       run_after;
   } instr_t;

   typedef struct {
      int cycles, req, we, rw, wb_at, src, br_at, end_state, ret, ir, pcw;
   } res_t;

   typedef struct {
      instr_t in;
      res_t   ex;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;
   int m_count = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic instr_t mk_in(input logic [5:0] op, input logic r, input logic w,
                                    input logic wb, input logic [1:0] br, input logic tk,
                                    input int fw, input int mw, input logic ra);
      instr_t i;
      i.op = op; i.r = r; i.w = w; i.wb = wb; i.br = br; i.tk = tk;
      i.fw = fw; i.mw = mw; i.run_after = ra;
      return i;
   endfunction

   function automatic res_t mk_ex(input int cyc, input int req, input int we, input int rw,
                                  input int wb_at, input int src, input int br_at,
                                  input int end_state, input int ret);
      res_t e;
      e.cycles = cyc; e.req = req; e.we = we; e.rw = rw; e.wb_at = wb_at;
      e.src = src; e.br_at = br_at; e.end_state = end_state; e.ret = ret;
      e.ir = 1; e.pcw = 1 + src;
      return e;
   endfunction

   // Reference: per-instruction cost and effects straight from the cycle rules.
   function automatic res_t model(input instr_t i);
      res_t e;
      int   n;
      e = '{default: 0};
      e.ir  = 1;
      e.pcw = 1;
      n     = i.fw + 1;
      e.req = i.fw + 1;
      n     = n + 1;
      if (i.op == 6'h3F) begin
         e.cycles = n; e.end_state = 6; e.ret = 0;
         return e;
      end
      e.ret = 1;
      e.end_state = i.run_after ? 1 : 0;
      if (i.op != 6'h00) begin
         n = n + 1;
         if (i.br == 2'b11 || ((i.br == 2'b01 || i.br == 2'b10) && i.tk)) begin
            e.src = 1; e.pcw = 2; e.br_at = n;
         end
         if (i.r || i.w) begin
            n     = n + i.mw + 1;
            e.req = e.req + i.mw + 1;
            if (i.w) e.we = i.mw + 1;
            if (i.r && i.wb && !i.w) begin
               n = n + 1; e.rw = 1; e.wb_at = n;
            end
         end else if (i.wb) begin
            n = n + 1; e.rw = 1; e.wb_at = n;
         end
      end
      e.cycles = n;
      return e;
   endfunction

   task automatic do_reset();
      rst = 1'b0; run = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      m_count = 0;
   endtask

   // Drive one instruction from FETCH to its boundary and tally observed strobes.
   task automatic apply(input instr_t in, output res_t t);
      bit         seen;
      int         fw, mw;
      logic [2:0] st;
      t = '{default: 0};
      if (state == 3'd6) do_reset();
      opcode = in.op; mem_r_en = in.r; mem_w_en = in.w; wb_en = in.wb;
      br_type = in.br; branch_taken = in.tk;
      if (state == 3'd0) begin
         run = 1'b1; mem_ready = 1'b0;
         @(negedge clk);
      end
      fw = in.fw; mw = in.mw; seen = 1'b0;
      for (int c = 0; c < 64; c++) begin
         st = state;
         if (st == 3'd1) begin
            mem_ready = (fw == 0); if (fw > 0) fw--;
         end else if (st == 3'd4) begin
            mem_ready = (mw == 0); if (mw > 0) mw--;
         end else begin
            mem_ready = 1'($urandom);
         end
         if (c == 0) run = in.run_after;
         #1;
         t.cycles++;
         if (st != 3'd1) seen = 1'b1;
         if (mem_req) t.req++;
         if (mem_req && mem_we) t.we++;
         if (ir_write) t.ir++;
         if (pc_write) t.pcw++;
         if (pc_write && pc_src_branch) begin t.src++; t.br_at = t.cycles; end
         if (reg_write) begin t.rw++; t.wb_at = t.cycles; end
         @(negedge clk);
         if (seen && (state == 3'd0 || state == 3'd1 || state == 3'd6)) break;
      end
      t.end_state = int'(state);
   endtask

   task automatic check_instr(input string tag, input res_t t, input res_t e);
      chk({tag, " cycles"},    t.cycles,    e.cycles);
      chk({tag, " mem_req"},   t.req,       e.req);
      chk({tag, " mem_we"},    t.we,        e.we);
      chk({tag, " reg_write"}, t.rw,        e.rw);
      chk({tag, " wb_cycle"},  t.wb_at,     e.wb_at);
      chk({tag, " pc_src"},    t.src,       e.src);
      chk({tag, " br_cycle"},  t.br_at,     e.br_at);
      chk({tag, " pc_write"},  t.pcw,       e.pcw);
      chk({tag, " ir_write"},  t.ir,        e.ir);
      chk({tag, " end_state"}, t.end_state, e.end_state);
      if (e.ret != 0 && m_count < SAT) m_count++;
      chk({tag, " count"}, int'(instr_count), m_count);
   endtask

   function automatic int strobes();
      return int'({pc_write, pc_src_branch, ir_write, id_latch, exe_latch, mem_req, mem_we, reg_write});
   endfunction

   vec_t   tbl [12];
   instr_t ri;
   res_t   got;

   initial begin
      //              op     r  w  wb br    tk fw mw ra            cyc req we rw wb src br end ret
      tbl[0]  = '{mk_in(6'h01, 0, 0, 1, 2'd0, 0, 0, 0, 1), mk_ex(4, 1, 0, 1, 4, 0, 0, 1, 1)};
      tbl[1]  = '{mk_in(6'h00, 0, 0, 1, 2'd0, 0, 0, 0, 1), mk_ex(2, 1, 0, 0, 0, 0, 0, 1, 1)};
      tbl[2]  = '{mk_in(6'h23, 1, 0, 1, 2'd0, 0, 0, 3, 1), mk_ex(8, 5, 0, 1, 8, 0, 0, 1, 1)};
      tbl[3]  = '{mk_in(6'h05, 0, 0, 0, 2'd2, 1, 0, 0, 1), mk_ex(3, 1, 0, 0, 0, 1, 3, 1, 1)};
      tbl[4]  = '{mk_in(6'h04, 0, 0, 0, 2'd1, 0, 0, 0, 1), mk_ex(3, 1, 0, 0, 0, 0, 0, 1, 1)};
      tbl[5]  = '{mk_in(6'h02, 0, 0, 0, 2'd3, 0, 1, 0, 1), mk_ex(4, 2, 0, 0, 0, 1, 4, 1, 1)};
      tbl[6]  = '{mk_in(6'h2B, 0, 1, 1, 2'd0, 0, 2, 0, 0), mk_ex(6, 4, 1, 0, 0, 0, 0, 0, 1)};
      tbl[7]  = '{mk_in(6'h2B, 1, 1, 1, 2'd0, 0, 0, 1, 1), mk_ex(5, 3, 2, 0, 0, 0, 0, 1, 1)};
      tbl[8]  = '{mk_in(6'h01, 0, 0, 0, 2'd0, 0, 0, 0, 1), mk_ex(3, 1, 0, 0, 0, 0, 0, 1, 1)};
      tbl[9]  = '{mk_in(6'h23, 1, 0, 0, 2'd0, 0, 0, 0, 1), mk_ex(4, 2, 0, 0, 0, 0, 0, 1, 1)};
      tbl[10] = '{mk_in(6'h01, 0, 0, 1, 2'd2, 0, 3, 0, 1), mk_ex(7, 4, 0, 1, 7, 0, 0, 1, 1)};
      tbl[11] = '{mk_in(6'h3F, 0, 0, 1, 2'd3, 1, 0, 0, 1), mk_ex(2, 1, 0, 0, 0, 0, 0, 6, 0)};

      opcode = '0; mem_r_en = 1'b0; mem_w_en = 1'b0; wb_en = 1'b0;
      br_type = '0; branch_taken = 1'b0;
      do_reset();

      chk("reset state",   int'(state),       0);
      chk("reset count",   int'(instr_count), 0);
      chk("reset fault",   int'(fault),       0);
      chk("reset busy",    int'(busy),        0);
      chk("reset strobes", strobes(),         0);

      for (int k = 0; k < 12; k++) begin
         apply(tbl[k].in, got);
         check_instr($sformatf("tbl%0d", k), got, tbl[k].ex);
      end

      for (int k = 0; k < 40; k++) begin
         ri.op = ($urandom_range(0, 5) == 0) ? 6'h00 : 6'($urandom_range(1, 62));
         ri.r = 1'($urandom); ri.w = 1'($urandom); ri.wb = 1'($urandom);
         ri.br = 2'($urandom); ri.tk = 1'($urandom);
         ri.fw = $urandom_range(0, 3); ri.mw = $urandom_range(0, 3);
         ri.run_after = ($urandom_range(0, 3) != 0);
         apply(ri, got);
         check_instr($sformatf("rnd%0d", k), got, model(ri));
      end

      // Fetch never completes: four wait cycles then HALT with fault.
      do_reset();
      opcode = 6'h01; run = 1'b1; mem_ready = 1'b0;
      @(negedge clk);
      chk("to fetch entered", int'(state), 1);
      repeat (3) @(negedge clk);
      chk("to 4th wait state",   int'(state),   1);
      chk("to 4th wait mem_req", int'(mem_req), 1);
      chk("to 4th wait fault",   int'(fault),   0);
      @(negedge clk);
      chk("to halt state",   int'(state), 6);
      chk("to halt fault",   int'(fault), 1);
      chk("to halt strobes", strobes(),   0);
      chk("to halt busy",    int'(busy),  0);
      mem_ready = 1'b1;
      @(negedge clk);
      chk("to halt absorbing", int'(state), 6);
      chk("to halt sticky",    int'(fault), 1);
      do_reset();
      chk("to reset state", int'(state), 0);
      chk("to reset fault", int'(fault), 0);

      // Reset while a store waits in MEM.
      opcode = 6'h2B; mem_r_en = 1'b0; mem_w_en = 1'b1; wb_en = 1'b0; br_type = 2'd0;
      run = 1'b1; mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      chk("rmem state",   int'(state),            4);
      chk("rmem request", int'(mem_req & mem_we), 1);
      rst = 1'b0;
      @(negedge clk);
      chk("rmem after state",     int'(state),       0);
      chk("rmem after mem_req",   int'(mem_req),     0);
      chk("rmem after reg_write", int'(reg_write),   0);
      chk("rmem after count",     int'(instr_count), 0);
      rst = 1'b1; run = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
